// File: rtl/aes_pkg.sv
// Shared types, encodings and parameter helpers for the AES serial controller.
// Macros AES_KEY_BITS_OK / AES_LANES_OK back the elaboration-time checks.
`ifndef AES_PKG_SV
`define AES_PKG_SV

`define AES_KEY_BITS_OK(k) (((k) == 128) || ((k) == 192) || ((k) == 256))
`define AES_LANES_OK(l) (((l) == 1) || ((l) == 2) || ((l) == 4))

package aes_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_KSTALL = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [1:0] KS_LOAD = 2'd0;
    localparam logic [1:0] KS_RCON = 2'd1;
    localparam logic [1:0] KS_SBOX = 2'd2;
    localparam logic [1:0] KS_NORM = 2'd3;

    localparam int CNT_W = 4;

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int beats_of(input int lanes);
        return 16 / lanes;
    endfunction

endpackage

`endif

// File: rtl/aes_beat_counter.sv
// Modulo-N counter with enable, terminal-count flag and synchronous clear.
// Used for the beat, key-stall and round counters of the AES controller.
module aes_beat_counter #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    generate
        if (N < 1 || N > (1 << W)) begin : g_bad_n
            $error("aes_beat_counter: N out of range for W");
        end
    endgenerate

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/aes_serial_ctrl.sv
// Sequencer for the byte-serial AES encrypt datapath and key expansion.
// Define AES_CTRL_PERF_EN to add the blk_cnt / stall_cnt counters.
module aes_serial_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_BITS  = 128,
    parameter int LANES     = 1,
    parameter int KEY_STALL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  beat_idx,
    output logic [3:0]  round_idx,
    output logic [1:0]  ks_phase,
    output logic        rcon_en,
    output logic        dp_shift,
    output logic        mc_en,
    output logic        pld,
    output logic        busy,
    output logic        done
`ifdef AES_CTRL_PERF_EN
    ,
    output logic [31:0] blk_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int NR    = nr_of(KEY_BITS);
    localparam int BEATS = beats_of(LANES);

    generate
        if (!`AES_KEY_BITS_OK(KEY_BITS)) begin : g_bad_key
            $error("aes_serial_ctrl: KEY_BITS must be 128, 192 or 256");
        end
        if (!`AES_LANES_OK(LANES)) begin : g_bad_lanes
            $error("aes_serial_ctrl: LANES must be 1, 2 or 4");
        end
        if (KEY_STALL < 1 || KEY_STALL > 16) begin : g_bad_stall
            $error("aes_serial_ctrl: KEY_STALL must be 1..16");
        end
    endgenerate

    state_t     state;
    logic       st_load;
    logic       st_kstall;
    logic       st_round;
    logic       st_drain;
    logic       in_hs;
    logic       out_hs;
    logic       beat_en;
    logic       beat_tc;
    logic       stall_tc;
    logic       round_en;
    logic       round_tc;
    logic       load_last;
    logic       round_last;
    logic       drain_last;
    logic       stall_first;
    logic       col_end;
    logic [3:0] stall_idx;
    logic [5:0] lane_pos;

    assign st_load   = (state == ST_LOAD);
    assign st_kstall = (state == ST_KSTALL);
    assign st_round  = (state == ST_ROUND);
    assign st_drain  = (state == ST_DRAIN);

    assign in_hs  = in_ready & in_valid;
    assign out_hs = out_valid & out_ready;

    assign load_last  = in_hs & beat_tc;
    assign round_last = st_round & beat_tc;
    assign drain_last = out_hs & beat_tc;

    // The beat counter wraps to zero by itself at every phase boundary.
    assign beat_en  = in_hs | st_round | out_hs;
    assign round_en = load_last | (round_last & ~round_tc);

    aes_beat_counter #(.N(BEATS), .W(CNT_W)) u_beat (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (beat_en),
        .cnt (beat_idx),
        .tc  (beat_tc)
    );

    aes_beat_counter #(.N(KEY_STALL), .W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (st_kstall),
        .cnt (stall_idx),
        .tc  (stall_tc)
    );

    aes_beat_counter #(.N(NR + 1), .W(CNT_W)) u_round (
        .clk (clk),
        .rst (rst),
        .clr (drain_last),
        .en  (round_en),
        .cnt (round_idx),
        .tc  (round_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (load_last) begin
                        state    <= ST_KSTALL;
                        in_ready <= 1'b0;
                    end
                end
                ST_KSTALL: begin
                    if (stall_tc) begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (beat_tc) begin
                        if (round_tc) begin
                            state     <= ST_DRAIN;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_KSTALL;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        state     <= ST_LOAD;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // A column completes when the bytes consumed so far fill a 4-byte word.
    assign lane_pos    = (6'(beat_idx) + 6'd1) * 6'(LANES);
    assign col_end     = (lane_pos[1:0] == 2'd0);
    assign stall_first = (stall_idx == '0);

    always_comb begin
        ks_phase = KS_LOAD;
        rcon_en  = 1'b0;
        dp_shift = 1'b0;
        mc_en    = 1'b0;
        pld      = 1'b0;
        unique case (1'b1)
            st_load: begin
                dp_shift = in_valid;
            end
            st_kstall: begin
                rcon_en  = stall_first;
                ks_phase = stall_first ? KS_RCON : KS_SBOX;
            end
            st_round: begin
                dp_shift = 1'b1;
                ks_phase = KS_NORM;
                mc_en    = ~round_tc;
                pld      = col_end;
            end
            st_drain: begin
                dp_shift = out_hs;
            end
            default: ;
        endcase
    end

    assign busy = ~(st_load & (beat_idx == '0));
    assign done = drain_last & ~rst;

`ifdef AES_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (done) begin
                blk_cnt <= blk_cnt + 32'd1;
            end
            if (st_drain && !out_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
